// File: rtl/mem_arbiter_if.sv
// Bundle of the I/D requester ports, the downstream memory port and the stall request.
// The arbiter uses the master view. The requesters and the memory model use the slave view.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  logic          flush_i;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_addr_ok;
  logic          i_data_ok;
  logic          d_req;
  logic          d_wr;
  logic [SW-1:0] d_wstrb;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_addr_ok;
  logic          d_data_ok;
  logic [DW-1:0] rdata_o;
  logic          m_req;
  logic          m_wr;
  logic [SW-1:0] m_wstrb;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_addr_ok;
  logic          m_data_ok;
  logic [DW-1:0] m_rdata;
  logic          stallreq_o;

  modport master (
    input  flush_i, i_req, i_addr, d_req, d_wr, d_wstrb, d_addr, d_wdata,
           m_addr_ok, m_data_ok, m_rdata,
    output i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, rdata_o,
           m_req, m_wr, m_wstrb, m_addr, m_wdata, stallreq_o
  );

  modport slave (
    output flush_i, i_req, i_addr, d_req, d_wr, d_wstrb, d_addr, d_wdata,
           m_addr_ok, m_data_ok, m_rdata,
    input  i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, rdata_o,
           m_req, m_wr, m_wstrb, m_addr, m_wdata, stallreq_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority (D over I) arbiter for a single sram-like memory port with one transaction
// outstanding. Fetches that are killed by a flush are discarded.
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT} st_t;

  st_t           st;
  logic          own;
  logic          drop;
  logic          m_req_q;
  logic          q_wr;
  logic [SW-1:0] q_wstrb;
  logic [AW-1:0] q_addr;
  logic [DW-1:0] q_wdata;
  logic [DW-1:0] rdata_q;

  logic d_acc;
  logic i_acc;
  logic done;

  // Acceptance and completion are decided in the same cycle as the request or the response.
  assign d_acc = !rst && (st == IDLE) && bus.d_req;
  assign i_acc = !rst && (st == IDLE) && !bus.d_req && bus.i_req;
  assign done  = !rst && (st == WAIT) && bus.m_data_ok;

  assign bus.d_addr_ok  = d_acc;
  assign bus.i_addr_ok  = i_acc;
  assign bus.d_data_ok  = done && own;
  assign bus.i_data_ok  = done && !own && !drop;
  assign bus.rdata_o    = done ? bus.m_rdata : rdata_q;
  assign bus.stallreq_o = (bus.d_req && !d_acc) ||
                          (!rst && own && (st != IDLE) && !done);

  assign bus.m_req   = m_req_q;
  assign bus.m_wr    = q_wr;
  assign bus.m_wstrb = q_wstrb;
  assign bus.m_addr  = q_addr;
  assign bus.m_wdata = q_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      own     <= 1'b0;
      drop    <= 1'b0;
      m_req_q <= 1'b0;
      q_wr    <= 1'b0;
      q_wstrb <= '0;
      q_addr  <= '0;
      q_wdata <= '0;
      rdata_q <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (d_acc) begin
            q_wr    <= bus.d_wr;
            q_wstrb <= bus.d_wstrb;
            q_addr  <= bus.d_addr;
            q_wdata <= bus.d_wdata;
            own     <= 1'b1;
            drop    <= 1'b0;
            m_req_q <= 1'b1;
            st      <= ADDR;
          end else if (i_acc) begin
            q_wr    <= 1'b0;
            q_wstrb <= '0;
            q_addr  <= bus.i_addr;
            q_wdata <= '0;
            own     <= 1'b0;
            drop    <= bus.flush_i;
            m_req_q <= 1'b1;
            st      <= ADDR;
          end
        end
        ADDR: begin
          // Data accesses already issued must complete visibly, so only a fetch can be dropped.
          if (bus.flush_i && !own) drop <= 1'b1;
          if (bus.m_addr_ok) begin
            m_req_q <= 1'b0;
            st      <= WAIT;
          end
        end
        WAIT: begin
          if (bus.m_data_ok) begin
            rdata_q <= bus.m_rdata;
            drop    <= 1'b0;
            st      <= IDLE;
          end else if (bus.flush_i && !own) begin
            drop <= 1'b1;
          end
        end
        default: begin
          m_req_q <= 1'b0;
          st      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-by-cycle vector bench for mem_arbiter: table rows plus hand-written
// stretched-handshake and mid-transaction reset sequences.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // e_ctl bit order: i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, stallreq_o, m_req
  typedef struct {
    string       name;
    logic        rst;
    logic        flush;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;
    logic [5:0]  e_ctl;
    logic        chk_f;
    logic        e_mwr;
    logic [3:0]  e_mwstrb;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic        chk_r;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t blank(input string n);
    vec_t x;
    x.name = n;       x.rst = 1'b0;     x.flush = 1'b0;   x.i_req = 1'b0;
    x.i_addr = '0;    x.d_req = 1'b0;   x.d_wr = 1'b0;    x.d_wstrb = '0;
    x.d_addr = '0;    x.d_wdata = '0;   x.m_addr_ok = 1'b0;
    x.m_data_ok = 1'b0; x.m_rdata = '0; x.e_ctl = '0;     x.chk_f = 1'b0;
    x.e_mwr = 1'b0;   x.e_mwstrb = '0;  x.e_maddr = '0;   x.e_mwdata = '0;
    x.chk_r = 1'b0;   x.e_rdata = '0;
    return x;
  endfunction

  function automatic vec_t fx(input vec_t x, input logic wr, input logic [3:0] s,
                              input logic [31:0] a, input logic [31:0] d);
    x.chk_f = 1'b1; x.e_mwr = wr; x.e_mwstrb = s; x.e_maddr = a; x.e_mwdata = d;
    return x;
  endfunction

  function automatic vec_t rd(input vec_t x, input logic [31:0] r);
    x.chk_r = 1'b1; x.e_rdata = r;
    return x;
  endfunction

  function automatic vec_t dreq(input vec_t x, input logic wr, input logic [3:0] s,
                                input logic [31:0] a, input logic [31:0] d);
    x.d_req = 1'b1; x.d_wr = wr; x.d_wstrb = s; x.d_addr = a; x.d_wdata = d;
    return x;
  endfunction

  task automatic step(input vec_t v);
    logic [5:0] act;
    @(negedge clk);
    rst           = v.rst;
    bus.flush_i   = v.flush;
    bus.i_req     = v.i_req;
    bus.i_addr    = v.i_addr;
    bus.d_req     = v.d_req;
    bus.d_wr      = v.d_wr;
    bus.d_wstrb   = v.d_wstrb;
    bus.d_addr    = v.d_addr;
    bus.d_wdata   = v.d_wdata;
    bus.m_addr_ok = v.m_addr_ok;
    bus.m_data_ok = v.m_data_ok;
    bus.m_rdata   = v.m_rdata;
    #1;
    act = {bus.i_addr_ok, bus.d_addr_ok, bus.i_data_ok, bus.d_data_ok, bus.stallreq_o, bus.m_req};
    checks++;
    if (act !== v.e_ctl) begin
      failures++;
      $display("FAIL %s ctl(iaok,daok,idok,ddok,stall,mreq) act=%b exp=%b", v.name, act, v.e_ctl);
    end
    if (v.chk_f) begin
      checks++;
      if ({bus.m_wr, bus.m_wstrb, bus.m_addr} !== {v.e_mwr, v.e_mwstrb, v.e_maddr}) begin
        failures++;
        $display("FAIL %s m_fields act wr=%b strb=%b addr=%h exp wr=%b strb=%b addr=%h", v.name,
                 bus.m_wr, bus.m_wstrb, bus.m_addr, v.e_mwr, v.e_mwstrb, v.e_maddr);
      end
      if (v.e_mwr || v.rst) begin
        checks++;
        if (bus.m_wdata !== v.e_mwdata) begin
          failures++;
          $display("FAIL %s m_wdata act=%h exp=%h", v.name, bus.m_wdata, v.e_mwdata);
        end
      end
    end
    if (v.chk_r) begin
      checks++;
      if (bus.rdata_o !== v.e_rdata) begin
        failures++;
        $display("FAIL %s rdata_o act=%h exp=%h", v.name, bus.rdata_o, v.e_rdata);
      end
    end
  endtask

  initial begin
    vec_t v;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.flush_i = 1'b0; bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0;
    bus.d_wr = 1'b0; bus.d_wstrb = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0; bus.m_rdata = '0;

    // Reset with both requests high, then D write wins the contention and I follows.
    for (int k = 0; k < 2; k++) begin
      v = blank($sformatf("rst%0d", k)); v.rst = 1'b1; v.i_req = 1'b1; v.d_req = 1'b1;
      v.e_ctl = 6'b000010; v = fx(v, 1'b0, 4'h0, 32'h0, 32'h0); v = rd(v, 32'h0); tbl.push_back(v);
    end
    v = blank("c0_dacc"); v.i_req = 1'b1; v.i_addr = 32'h100;
    v = dreq(v, 1'b1, 4'b0011, 32'h1000_0004, 32'h5A5A_5A5A); v.e_ctl = 6'b010000; tbl.push_back(v);
    v = blank("c1_daddr"); v.i_req = 1'b1; v.i_addr = 32'h100; v.m_addr_ok = 1'b1;
    v.e_ctl = 6'b000011; v = fx(v, 1'b1, 4'b0011, 32'h1000_0004, 32'h5A5A_5A5A); tbl.push_back(v);
    v = blank("c2_dwait"); v.i_req = 1'b1; v.i_addr = 32'h100; v.e_ctl = 6'b000010; tbl.push_back(v);
    v = blank("c3_ddone"); v.i_req = 1'b1; v.i_addr = 32'h100; v.m_data_ok = 1'b1;
    v.m_rdata = 32'h1111_2222; v.e_ctl = 6'b000100; v = rd(v, 32'h1111_2222); tbl.push_back(v);
    v = blank("c4_iacc"); v.i_req = 1'b1; v.i_addr = 32'h100; v.e_ctl = 6'b100000; tbl.push_back(v);
    v = blank("c5_iaddr"); v.m_addr_ok = 1'b1; v.e_ctl = 6'b000001;
    v = fx(v, 1'b0, 4'h0, 32'h100, 32'h0); tbl.push_back(v);
    v = blank("c6_idone"); v.m_data_ok = 1'b1; v.m_rdata = 32'hDEAD_BEEF; v.e_ctl = 6'b001000;
    v = rd(v, 32'hDEAD_BEEF); tbl.push_back(v);
    v = blank("c7_idle"); tbl.push_back(v);

    // Flush during an I wait: response swallowed, next fetch delivered.
    v = blank("f0_iacc"); v.i_req = 1'b1; v.i_addr = 32'h8000_0000; v.e_ctl = 6'b100000; tbl.push_back(v);
    v = blank("f1_iaddr"); v.m_addr_ok = 1'b1; v.e_ctl = 6'b000001;
    v = fx(v, 1'b0, 4'h0, 32'h8000_0000, 32'h0); tbl.push_back(v);
    v = blank("f2_flush"); v.flush = 1'b1; tbl.push_back(v);
    v = blank("f3_wait"); tbl.push_back(v);
    v = blank("f4_dropped"); v.m_data_ok = 1'b1; v.m_rdata = 32'hCAFE_F00D; tbl.push_back(v);
    v = blank("f5_iacc"); v.i_req = 1'b1; v.i_addr = 32'h8000_0010; v.e_ctl = 6'b100000; tbl.push_back(v);
    v = blank("f6_iaddr"); v.m_addr_ok = 1'b1; v.e_ctl = 6'b000001;
    v = fx(v, 1'b0, 4'h0, 32'h8000_0010, 32'h0); tbl.push_back(v);
    v = blank("f7_idone"); v.m_data_ok = 1'b1; v.m_rdata = 32'h1234_5678; v.e_ctl = 6'b001000;
    v = rd(v, 32'h1234_5678); tbl.push_back(v);

    // Flush in the acceptance cycle drops the fetch. Flush in an idle cycle is ignored.
    v = blank("g0_iacc_fl"); v.i_req = 1'b1; v.i_addr = 32'h8000_0020; v.flush = 1'b1;
    v.e_ctl = 6'b100000; tbl.push_back(v);
    v = blank("g1_iaddr"); v.m_addr_ok = 1'b1; v.e_ctl = 6'b000001;
    v = fx(v, 1'b0, 4'h0, 32'h8000_0020, 32'h0); tbl.push_back(v);
    v = blank("g2_dropped"); v.m_data_ok = 1'b1; v.m_rdata = 32'hFFFF_0000; tbl.push_back(v);
    v = blank("g3_idle_fl"); v.flush = 1'b1; tbl.push_back(v);
    v = blank("g4_iacc"); v.i_req = 1'b1; v.i_addr = 32'h8000_0030; v.e_ctl = 6'b100000; tbl.push_back(v);
    v = blank("g5_iaddr"); v.m_addr_ok = 1'b1; v.e_ctl = 6'b000001;
    v = fx(v, 1'b0, 4'h0, 32'h8000_0030, 32'h0); tbl.push_back(v);
    v = blank("g6_idone"); v.m_data_ok = 1'b1; v.m_rdata = 32'h5555_AAAA; v.e_ctl = 6'b001000;
    v = rd(v, 32'h5555_AAAA); tbl.push_back(v);

    // Flush while D owns the port never hides the completion.
    v = blank("d0_dacc"); v = dreq(v, 1'b0, 4'h0, 32'h2000_0008, 32'h0); v.e_ctl = 6'b010000; tbl.push_back(v);
    v = blank("d1_daddr_fl"); v.m_addr_ok = 1'b1; v.flush = 1'b1; v.e_ctl = 6'b000011;
    v = fx(v, 1'b0, 4'h0, 32'h2000_0008, 32'h0); tbl.push_back(v);
    v = blank("d2_dwait_fl"); v.flush = 1'b1; v.e_ctl = 6'b000010; tbl.push_back(v);
    v = blank("d3_ddone"); v.m_data_ok = 1'b1; v.m_rdata = 32'hA5A5_0F0F; v.e_ctl = 6'b000100;
    v = rd(v, 32'hA5A5_0F0F); tbl.push_back(v);

    foreach (tbl[i]) step(tbl[i]);

    // Stretched downstream accept: request held stable, both requesters kept waiting.
    v = blank("s_dacc"); v = dreq(v, 1'b1, 4'b1100, 32'h3000_000C, 32'hBEEF_0000);
    v.e_ctl = 6'b010000; step(v);
    for (int k = 0; k < 5; k++) begin
      v = blank($sformatf("s_hold%0d", k)); v.i_req = 1'b1; v.i_addr = 32'h200;
      v = dreq(v, 1'b1, 4'b1111, 32'h3000_0010, 32'h0101_0101); v.e_ctl = 6'b000011;
      v = fx(v, 1'b1, 4'b1100, 32'h3000_000C, 32'hBEEF_0000); step(v);
    end
    v = blank("s_aok"); v.i_req = 1'b1; v.i_addr = 32'h200; v.m_addr_ok = 1'b1; v.e_ctl = 6'b000011;
    v = fx(v, 1'b1, 4'b1100, 32'h3000_000C, 32'hBEEF_0000); step(v);
    v = blank("s_ddone"); v.i_req = 1'b1; v.i_addr = 32'h200; v.m_data_ok = 1'b1;
    v.m_rdata = 32'h0BAD_F00D; v.e_ctl = 6'b000100; v = rd(v, 32'h0BAD_F00D); step(v);
    v = blank("s_iacc"); v.i_req = 1'b1; v.i_addr = 32'h200; v.e_ctl = 6'b100000; step(v);
    v = blank("s_iaddr"); v.m_addr_ok = 1'b1; v.e_ctl = 6'b000001;
    v = fx(v, 1'b0, 4'h0, 32'h200, 32'h0); step(v);
    v = blank("s_idone"); v.m_data_ok = 1'b1; v.m_rdata = 32'h0000_0077; v.e_ctl = 6'b001000;
    v = rd(v, 32'h0000_0077); step(v);

    // Reset in the middle of a D transaction abandons it.
    v = blank("r_dacc"); v = dreq(v, 1'b0, 4'h0, 32'h4000_0004, 32'h0); v.e_ctl = 6'b010000; step(v);
    v = blank("r_daddr"); v.e_ctl = 6'b000011; v = fx(v, 1'b0, 4'h0, 32'h4000_0004, 32'h0); step(v);
    v = blank("r_rst"); v.rst = 1'b1; v.e_ctl = 6'b000001;
    v = fx(v, 1'b0, 4'h0, 32'h4000_0004, 32'h0); step(v);
    v = blank("r_post"); v.e_ctl = 6'b000000; v = fx(v, 1'b0, 4'h0, 32'h0, 32'h0); step(v);
    v = blank("r_iacc"); v.i_req = 1'b1; v.i_addr = 32'h300; v.e_ctl = 6'b100000; step(v);
    v = blank("r_iaddr"); v.m_addr_ok = 1'b1; v.e_ctl = 6'b000001;
    v = fx(v, 1'b0, 4'h0, 32'h300, 32'h0); step(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
